// File: rtl/smc_stream.sv
// smc_stream: streaming SMC evaluator. One device per accept, running
// top-K / bottom-K selection in a sorted buffer, weighted-sum strobe per batch.
module smc_stream #(
  parameter int NUM_DEV = 6,
  parameter int K       = 3,
  parameter int DW      = 3,
  parameter int OUT_W   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [DW-1:0]    W,
  input  logic [DW-1:0]    V_GS,
  input  logic [DW-1:0]    V_DS,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_n
);

  localparam int PW = 3 * DW + 1;
  localparam int CW = $clog2(NUM_DEV + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SUM} state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d, mode_eff;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     buf_q [K];
  logic [PW-1:0]     buf_d [K];
  logic [K-1:0]      vld_q, vld_d;
  logic              out_valid_q;
  logic [OUT_W-1:0]  out_n_q, out_n_d;
  logic              accept;

  logic              triode;
  logic [DW-1:0]     vgs_m1;
  logic [PW-1:0]     w_e, vgs_e, vds_e, vm1_e, prod, dev_val;

  logic [PW-1:0]     s_val [K];
  logic [K-1:0]      s_vld;
  logic              full, top, ins, found;
  int unsigned       pos;

  assign in_ready  = (state_q != S_SUM);
  assign accept    = in_valid && in_ready;
  assign mode_eff  = (state_q == S_IDLE) ? mode : mode_q;
  assign out_valid = out_valid_q;
  assign out_n     = out_n_q;

  // Device value: region select, ID or gm product, then floor divide by 3.
  always_comb begin
    vgs_m1 = V_GS - DW'(1);
    w_e    = PW'(W);
    vgs_e  = PW'(V_GS);
    vds_e  = PW'(V_DS);
    vm1_e  = PW'(vgs_m1);
    triode = ({1'b0, V_GS} > ({1'b0, V_DS} + (DW+1)'(1)));
    if (triode) begin
      prod = mode_eff[0] ? vds_e * w_e * ((vgs_e << 1) - vds_e - PW'(2))
                         : (w_e * vds_e) << 1;
    end else begin
      prod = mode_eff[0] ? w_e * vm1_e * vm1_e
                         : (w_e * vm1_e) << 1;
    end
    dev_val = prod / PW'(3);
  end

  // Sorted buffer update. In bottom mode a full buffer first sheds its
  // largest entry (index 0), so both modes reduce to one descending insert.
  always_comb begin
    full  = &vld_q;
    top   = mode_eff[1];
    s_val = buf_q;
    s_vld = vld_q;
    buf_d = buf_q;
    vld_d = vld_q;
    pos   = K;
    found = 1'b0;
    if (!top && full) begin
      for (int unsigned i = 0; i < K - 1; i++) begin
        s_val[i] = buf_q[i+1];
        s_vld[i] = vld_q[i+1];
      end
      s_val[K-1] = '0;
      s_vld[K-1] = 1'b0;
    end
    ins = !full || (top ? (dev_val > buf_q[K-1]) : (dev_val < buf_q[0]));
    for (int unsigned i = 0; i < K; i++) begin
      if (!found && (!s_vld[i] || dev_val > s_val[i])) begin
        pos   = i;
        found = 1'b1;
      end
    end
    if (state_q == S_SUM) begin
      for (int unsigned i = 0; i < K; i++) buf_d[i] = '0;
      vld_d = '0;
    end else if (accept && ins) begin
      for (int unsigned i = 0; i < K; i++) begin
        if (i > pos) begin
          buf_d[i] = s_val[i-1];
          vld_d[i] = s_vld[i-1];
        end else if (i == pos) begin
          buf_d[i] = dev_val;
          vld_d[i] = 1'b1;
        end else begin
          buf_d[i] = s_val[i];
          vld_d[i] = s_vld[i];
        end
      end
    end
  end

  // Weighted sum of the selected group. Accumulated modulo 2^OUT_W, which
  // gives the same low bits as a full-width sum followed by truncation.
  always_comb begin
    out_n_d = '0;
    for (int unsigned i = 0; i < K; i++) begin
      if (vld_q[i]) begin
        out_n_d = out_n_d + OUT_W'(buf_q[i]) *
                  (mode_q[0] ? OUT_W'(32'd3 + i) : OUT_W'(1));
      end
    end
  end

  // Next-state logic: batch counting and mode capture on first accept.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mode_d  = mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          mode_d  = mode;
          count_d = count_q + CW'(1);
          state_d = ((count_q + CW'(1)) == CW'(NUM_DEV)) ? S_SUM : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept) begin
          count_d = count_q + CW'(1);
          if ((count_q + CW'(1)) == CW'(NUM_DEV)) state_d = S_SUM;
        end
      end
      S_SUM: begin
        count_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, buffer and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      count_q     <= '0;
      vld_q       <= '0;
      for (int unsigned i = 0; i < K; i++) buf_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_n_q     <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      count_q     <= count_d;
      vld_q       <= vld_d;
      buf_q       <= buf_d;
      out_valid_q <= (state_q == S_SUM);
      if (state_q == S_SUM) out_n_q <= out_n_d;
    end
  end

endmodule
